// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL divider control path.
package pll_ctrl_pkg;

  localparam int DIV_W   = 3;
  localparam int DIV_MIN = 1;
  localparam int DIV_MAX = 7;

  // Defaults shared with the pll_core benches.
  localparam int PLL_DEFAULT_DIV   = 4;
  localparam int PLL_SETTLE_CYCLES = 4;
  localparam int PLL_LOCK_STABLE   = 8;
  localparam int PLL_LOCK_TIMEOUT  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GATE      = 3'd1,
    ST_APPLY     = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_ENABLE    = 3'd4,
    ST_ERROR     = 3'd5
  } seq_state_t;

  // A divisor is usable only inside the range pll_core supports.
  function automatic logic div_is_legal(input logic [DIV_W-1:0] d);
    return (int'(d) >= DIV_MIN) && (int'(d) <= DIV_MAX);
  endfunction

endpackage

// File: rtl/pll_div_sequencer_if.sv
// Request handshake plus the pll_core control/status signals of the sequencer.
interface pll_div_sequencer_if;
  import pll_ctrl_pkg::*;

  logic             req_valid;
  logic [DIV_W-1:0] req_div;
  logic             req_ready;
  logic             locked;
  logic [DIV_W-1:0] div_num;
  logic             clk_out_enable;
  logic             busy;
  logic             done;
  logic             err_timeout;
  logic             err_illegal;

  modport master (
    output req_valid, req_div, locked,
    input  req_ready, div_num, clk_out_enable, busy, done, err_timeout, err_illegal
  );

  modport slave (
    input  req_valid, req_div, locked,
    output req_ready, div_num, clk_out_enable, busy, done, err_timeout, err_illegal
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, clears to 0 on reset.
module sync_2ff (
  input  logic clk_in,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Shift the async level through two flops to settle metastability.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pll_div_sequencer.sv
// Safe divisor reprogramming for pll_core: gate, apply, wait for stable
// relock (bounded by a timeout), re-enable. Also relocks after lock loss.
module pll_div_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int DEFAULT_DIV   = PLL_DEFAULT_DIV,
  parameter int SETTLE_CYCLES = PLL_SETTLE_CYCLES,
  parameter int LOCK_STABLE   = PLL_LOCK_STABLE,
  parameter int LOCK_TIMEOUT  = PLL_LOCK_TIMEOUT
) (
  input logic               clk_in,
  input logic               rst,
  pll_div_sequencer_if.slave bus
);

  localparam int SETTLE_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int STABLE_W  = $clog2(LOCK_STABLE + 1);
  localparam int TIMEOUT_W = $clog2(LOCK_TIMEOUT + 1);

  seq_state_t           r_state;
  seq_state_t           w_next;
  logic [DIV_W-1:0]     r_div_latch;
  logic [DIV_W-1:0]     r_div_num;
  logic [SETTLE_W-1:0]  r_settle;
  logic [STABLE_W-1:0]  r_stable;
  logic [TIMEOUT_W-1:0] r_timeout;
  logic                 r_oe;
  logic                 r_done;
  logic                 r_err_timeout;
  logic                 r_err_illegal;

  logic w_lock_s;
  logic w_xfer;
  logic w_legal;
  logic w_settle_end;
  logic w_stable_hit;
  logic w_timeout_hit;

  sync_2ff u_lock_sync (
    .clk_in  (clk_in),
    .rst     (rst),
    .i_async (bus.locked),
    .o_sync  (w_lock_s)
  );

  assign bus.req_ready = ((r_state == ST_IDLE) || (r_state == ST_ERROR)) && !rst;
  assign bus.busy      = (r_state != ST_IDLE);

  assign w_xfer        = bus.req_valid && bus.req_ready;
  assign w_legal       = div_is_legal(bus.req_div);
  assign w_settle_end  = (r_settle == SETTLE_W'(SETTLE_CYCLES - 1));
  assign w_stable_hit  = (r_stable == STABLE_W'(LOCK_STABLE));
  assign w_timeout_hit = (r_timeout == TIMEOUT_W'(LOCK_TIMEOUT));

  // Sequencer transitions; a transfer beats lock loss in IDLE, lock beats timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (w_legal) w_next = ST_GATE;
        end else if (!w_lock_s) begin
          w_next = ST_WAIT_LOCK;
        end
      end
      ST_GATE:      if (w_settle_end) w_next = ST_APPLY;
      ST_APPLY:     w_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (w_stable_hit)       w_next = ST_ENABLE;
        else if (w_timeout_hit) w_next = ST_ERROR;
      end
      ST_ENABLE:    w_next = ST_IDLE;
      ST_ERROR:     if (w_xfer && w_legal) w_next = ST_GATE;
      default:      w_next = ST_WAIT_LOCK;
    endcase
  end

  // State and registered outputs, decoded from the state being entered.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state       <= ST_WAIT_LOCK;
      r_div_num     <= DIV_W'(DEFAULT_DIV);
      r_oe          <= 1'b0;
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_illegal <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_oe          <= (w_next == ST_IDLE) || (w_next == ST_ENABLE);
      r_done        <= (w_next == ST_ENABLE);
      r_err_timeout <= (w_next == ST_ERROR);
      r_err_illegal <= w_xfer && !w_legal;
      if (r_state == ST_APPLY) r_div_num <= r_div_latch;
    end
  end

  // Capture the requested divisor; it only reaches pll_core through APPLY.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_div_latch <= DIV_W'(DEFAULT_DIV);
    end else if (w_xfer && w_legal) begin
      r_div_latch <= bus.req_div;
    end
  end

  // Saturating counters, live only in their own state and cleared elsewhere.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_settle  <= '0;
      r_stable  <= '0;
      r_timeout <= '0;
    end else begin
      if (r_state == ST_GATE) begin
        if (r_settle != SETTLE_W'(SETTLE_CYCLES)) r_settle <= r_settle + 1'b1;
      end else begin
        r_settle <= '0;
      end

      if (r_state == ST_WAIT_LOCK) begin
        if (!w_lock_s) r_stable <= '0;
        else if (!w_stable_hit) r_stable <= r_stable + 1'b1;
        if (!w_timeout_hit) r_timeout <= r_timeout + 1'b1;
      end else begin
        r_stable  <= '0;
        r_timeout <= '0;
      end
    end
  end

  assign bus.div_num        = r_div_num;
  assign bus.clk_out_enable = r_oe;
  assign bus.done           = r_done;
  assign bus.err_timeout    = r_err_timeout;
  assign bus.err_illegal    = r_err_illegal;

endmodule

// File: tb/tb_pll_div_sequencer.sv
// Bench for pll_div_sequencer: a timeline model of the sequencer compared
// against the DUT every cycle, plus literal latency and value checks.
module tb_pll_div_sequencer;
  import pll_ctrl_pkg::*;

  localparam int DEF_DIV = 4;
  localparam int SETTLE  = 4;
  localparam int STABLE  = 8;
  localparam int TIMEOUT = 1024;
  localparam int MAXC    = 8192;

  localparam int M_IDLE   = 0;
  localparam int M_GATE   = 1;
  localparam int M_APPLY  = 2;
  localparam int M_WAIT   = 3;
  localparam int M_ENABLE = 4;
  localparam int M_ERROR  = 5;

  logic clk_in = 1'b0;
  logic rst;

  pll_div_sequencer_if bus();

  pll_div_sequencer #(
    .DEFAULT_DIV   (DEF_DIV),
    .SETTLE_CYCLES (SETTLE),
    .LOCK_STABLE   (STABLE),
    .LOCK_TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit modelValid = 1'b0;

  bit rstArr[MAXC];
  bit lockedArr[MAXC];
  bit lockSArr[MAXC];

  int mPhase = M_WAIT;
  int mDiv = DEF_DIV;
  int mPend = DEF_DIV;
  int mGateLeft = 0;
  int mWaitStart = 0;
  bit mOe = 1'b0;
  bit mDone = 1'b0;
  bit mErrT = 1'b0;
  bit mErrI = 1'b0;

  // Advance the model from cycle c (inputs seen in c) to cycle c+1.
  task automatic modelStep(input int c, input bit valid, input int reqDiv);
    bit xfer;
    bit legal;
    bit ok;
    if (rstArr[c]) begin
      mPhase = M_WAIT;
      mWaitStart = c + 1;
      mDiv = DEF_DIV;
      mOe = 1'b0;
      mDone = 1'b0;
      mErrT = 1'b0;
      mErrI = 1'b0;
      return;
    end
    xfer  = valid && (mPhase == M_IDLE || mPhase == M_ERROR);
    legal = (reqDiv >= 1) && (reqDiv <= 7);
    mErrI = xfer && !legal;
    case (mPhase)
      M_IDLE: begin
        if (xfer) begin
          if (legal) begin
            mPend = reqDiv;
            mGateLeft = SETTLE;
            mPhase = M_GATE;
          end
        end else if (!lockSArr[c]) begin
          mPhase = M_WAIT;
          mWaitStart = c + 1;
        end
      end
      M_GATE: begin
        mGateLeft--;
        if (mGateLeft == 0) mPhase = M_APPLY;
      end
      M_APPLY: begin
        mDiv = mPend;
        mPhase = M_WAIT;
        mWaitStart = c + 1;
      end
      M_WAIT: begin
        ok = (c - STABLE >= mWaitStart);
        if (ok) for (int k = c - STABLE; k < c; k++) if (!lockSArr[k]) ok = 1'b0;
        if (ok) mPhase = M_ENABLE;
        else if (c - mWaitStart >= TIMEOUT) mPhase = M_ERROR;
      end
      M_ENABLE: mPhase = M_IDLE;
      M_ERROR: begin
        if (xfer && legal) begin
          mPend = reqDiv;
          mGateLeft = SETTLE;
          mPhase = M_GATE;
        end
      end
      default: ;
    endcase
    mOe   = (mPhase == M_IDLE) || (mPhase == M_ENABLE);
    mDone = (mPhase == M_ENABLE);
    mErrT = (mPhase == M_ERROR);
  endtask

  // Record this cycle's inputs, derive the synchronized lock, step the model.
  always @(posedge clk_in) begin
    if (cyc >= MAXC) begin
      errors++;
      $display("[TB] FAIL cycle budget: got %0d cycles, expected fewer than %0d", cyc, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    rstArr[cyc]    = rst;
    lockedArr[cyc] = bus.locked;
    lockSArr[cyc]  = 1'b0;
    if (cyc >= 2) lockSArr[cyc] = !rstArr[cyc-1] && !rstArr[cyc-2] && lockedArr[cyc-2];
    modelStep(cyc, bus.req_valid, int'(bus.req_div));
    if (rst) modelValid = 1'b1;
    cyc++;
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk_in) begin
    logic [8:0] expV;
    logic [8:0] actV;
    if (modelValid) begin
      expV = {((mPhase == M_IDLE) || (mPhase == M_ERROR)) && !rst, mPhase != M_IDLE,
              mOe, mDone, mErrT, mErrI, 3'(mDiv)};
      actV = {bus.req_ready, bus.busy, bus.clk_out_enable, bus.done,
              bus.err_timeout, bus.err_illegal, bus.div_num};
      checks++;
      if (actV !== expV) begin
        errors++;
        $display("[TB] FAIL cycle %0d outputs rdy/busy/oe/done/errT/errI/div: got %b, expected %b",
                 cyc, actV, expV);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit valid, input logic [2:0] div, input bit lockIn);
    bus.req_valid = valid;
    bus.req_div   = div;
    bus.locked    = lockIn;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Wait for done (or err_timeout) within a cycle budget; count cycles waited.
  task automatic waitFlag(input string name, input bit useErr, input int budget, output int waited);
    waited = 0;
    while (((useErr ? bus.err_timeout : bus.done) !== 1'b1) && waited < budget) begin
      tick(1);
      waited++;
    end
    if (waited >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no flag after %0d cycles, expected it within budget", name, budget);
    end
  endtask

  initial begin
    int waited;

    // Reset with the PLL already locked, then release and relock.
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b1);
    tick(3);
    checkOutput("reset div_num", bus.div_num, DEF_DIV);
    checkOutput("reset clk_out_enable", bus.clk_out_enable, 0);
    checkOutput("reset req_ready", bus.req_ready, 0);
    checkOutput("reset busy", bus.busy, 1);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset err_timeout", bus.err_timeout, 0);
    checkOutput("reset err_illegal", bus.err_illegal, 0);
    rst = 1'b0;
    tick(10);
    checkOutput("relock oe at +10", bus.clk_out_enable, 0);
    checkOutput("relock div at +10", bus.div_num, 4);
    tick(1);
    checkOutput("relock oe at +11", bus.clk_out_enable, 1);
    checkOutput("relock done at +11", bus.done, 1);
    tick(1);
    checkOutput("idle busy", bus.busy, 0);
    checkOutput("done width", bus.done, 0);

    // Normal change to divisor 2.
    applyStimulus(1'b1, 3'd2, 1'b1);
    checkOutput("idle req_ready", bus.req_ready, 1);
    tick(1);
    applyStimulus(1'b0, 3'd2, 1'b1);
    checkOutput("gate req_ready", bus.req_ready, 0);
    checkOutput("gate oe", bus.clk_out_enable, 0);
    tick(4);
    checkOutput("apply old div", bus.div_num, 4);
    tick(1);
    checkOutput("new div at +6", bus.div_num, 2);
    tick(8);
    checkOutput("oe low at +14", bus.clk_out_enable, 0);
    checkOutput("no done at +14", bus.done, 0);
    tick(1);
    checkOutput("done at +15", bus.done, 1);
    checkOutput("oe high at +15", bus.clk_out_enable, 1);
    tick(1);
    checkOutput("done one cycle", bus.done, 0);

    // Illegal divisor in IDLE.
    applyStimulus(1'b1, 3'd0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("illegal pulse", bus.err_illegal, 1);
    checkOutput("illegal keeps div", bus.div_num, 2);
    checkOutput("illegal keeps oe", bus.clk_out_enable, 1);
    checkOutput("illegal stays idle", bus.busy, 0);
    tick(1);
    checkOutput("illegal pulse width", bus.err_illegal, 0);

    // req_valid held through a sequence: second divisor waits for IDLE.
    applyStimulus(1'b1, 3'd5, 1'b1);
    tick(1);
    applyStimulus(1'b1, 3'd7, 1'b1);
    tick(5);
    checkOutput("held req div 5", bus.div_num, 5);
    tick(8);
    checkOutput("held req no early xfer", bus.div_num, 5);
    tick(1);
    checkOutput("held req done", bus.done, 1);
    tick(1);
    checkOutput("held req ready in idle", bus.req_ready, 1);
    tick(1);
    applyStimulus(1'b0, 3'd7, 1'b1);
    tick(5);
    checkOutput("held req div 7", bus.div_num, 7);
    waitFlag("held req second done", 1'b0, 30, waited);
    tick(1);

    // Relock timeout with locked stuck low, then recovery.
    applyStimulus(1'b1, 3'd6, 1'b0);
    tick(1);
    applyStimulus(1'b0, 3'd6, 1'b0);
    waitFlag("timeout flag", 1'b1, 1100, waited);
    checkOutput("timeout latency", waited + 1, 1031);
    checkOutput("timeout oe", bus.clk_out_enable, 0);
    checkOutput("error ready", bus.req_ready, 1);
    checkOutput("timeout div applied", bus.div_num, 6);
    applyStimulus(1'b1, 3'd0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkOutput("error illegal pulse", bus.err_illegal, 1);
    checkOutput("error stays sticky", bus.err_timeout, 1);
    tick(2);
    applyStimulus(1'b1, 3'd3, 1'b1);
    tick(1);
    applyStimulus(1'b0, 3'd3, 1'b1);
    checkOutput("recovery clears err", bus.err_timeout, 0);
    waitFlag("recovery done", 1'b0, 30, waited);
    checkOutput("recovery latency", waited + 1, 15);
    checkOutput("recovery div", bus.div_num, 3);
    tick(1);

    // Glitchy lock during WAIT_LOCK.
    applyStimulus(1'b1, 3'd1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 3'd1, 1'b0);
    tick(5);
    applyStimulus(1'b0, 3'd1, 1'b1);
    tick(5);
    applyStimulus(1'b0, 3'd1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 3'd1, 1'b1);
    tick(5);
    checkOutput("glitch no early enable", bus.done, 0);
    tick(5);
    checkOutput("glitch not yet", bus.done, 0);
    tick(1);
    checkOutput("glitch enable", bus.done, 1);
    checkOutput("glitch div", bus.div_num, 1);
    tick(1);

    // Spontaneous loss of lock in IDLE.
    applyStimulus(1'b0, 3'd1, 1'b0);
    tick(2);
    checkOutput("loss oe still high", bus.clk_out_enable, 1);
    tick(1);
    checkOutput("loss oe low", bus.clk_out_enable, 0);
    applyStimulus(1'b0, 3'd1, 1'b1);
    waitFlag("loss relock done", 1'b0, 40, waited);
    checkOutput("loss relock latency", waited, 11);
    checkOutput("loss keeps div", bus.div_num, 1);
    tick(1);

    // Reset during GATE aborts the pending divisor.
    applyStimulus(1'b1, 3'd6, 1'b1);
    tick(1);
    applyStimulus(1'b0, 3'd6, 1'b1);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("abort busy", bus.busy, 1);
    checkOutput("abort oe", bus.clk_out_enable, 0);
    checkOutput("abort div", bus.div_num, 4);
    waitFlag("abort relock done", 1'b0, 40, waited);
    checkOutput("abort div after relock", bus.div_num, 4);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
